// File: rtl/wide_byte_sched_pkg.sv
// Shared types and width helpers for the wide-word byte scheduler.
package wide_byte_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned qid_width(input int unsigned num_queues);
    return (num_queues < 2) ? 1 : $clog2(num_queues);
  endfunction

endpackage

// File: rtl/wide_byte_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer, wrapping.
module rr_arbiter
  import wide_byte_sched_pkg::*;
#(
  parameter int unsigned NUM_QUEUES = 8
) (
  input  logic [NUM_QUEUES-1:0]                req,
  input  logic [qid_width(NUM_QUEUES)-1:0]     ptr,
  output logic [NUM_QUEUES-1:0]                grant
);

  localparam int unsigned QW = qid_width(NUM_QUEUES);

  logic [QW-1:0] cand;
  logic          found;

  // NUM_QUEUES is a power of two, so the QW-bit sum wraps modulo NUM_QUEUES.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      cand = ptr + QW'(i);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wide_byte_sched.sv
// Round-robin scheduler serializing one wide word per grant into an MSB-first byte stream.
module wide_byte_sched
  import wide_byte_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 480,
  parameter int unsigned CTRL_WIDTH = 32,
  parameter int unsigned NUM_QUEUES = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctl,
  input  logic [NUM_QUEUES-1:0]            in_valid,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [7:0]                       out_data,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic                             out_sof,
  output logic                             out_eof,
  output logic [qid_width(NUM_QUEUES)-1:0] out_qid,
  output logic [CTRL_WIDTH-1:0]            out_ctl
);

  localparam int unsigned BYTES = bytes_per_word(DATA_WIDTH);
  localparam int unsigned QW    = qid_width(NUM_QUEUES);
  localparam int unsigned IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [QW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] word_q;
  logic [NUM_QUEUES-1:0] grant;
  logic [QW-1:0]         g_idx;
  logic                  xfer;
  logic                  can_grant;
  logic                  grant_fire;

  rr_arbiter #(
    .NUM_QUEUES(NUM_QUEUES)
  ) u_arb (
    .req  (in_valid),
    .ptr  (ptr),
    .grant(grant)
  );

  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      if (grant[i]) g_idx = QW'(i);
    end
  end

  assign xfer       = out_wr & out_rdy;
  assign can_grant  = !rst && ((state == IDLE) || (xfer && out_eof));
  assign in_rdy     = can_grant ? grant : '0;
  assign grant_fire = |in_rdy;
  assign out_data   = word_q[DATA_WIDTH-1 -: 8];

  // The word register shifts left by a byte per transfer, so the top byte is always current;
  // it is zeroed on return to IDLE to keep out_data at 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      ptr     <= '0;
      word_q  <= '0;
      out_wr  <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      out_qid <= '0;
      out_ctl <= '0;
    end else if (grant_fire) begin
      state   <= SHIFT;
      idx     <= '0;
      ptr     <= g_idx + QW'(1);
      word_q  <= in_data[g_idx*DATA_WIDTH +: DATA_WIDTH];
      out_ctl <= in_ctl[g_idx*CTRL_WIDTH +: CTRL_WIDTH];
      out_qid <= g_idx;
      out_wr  <= 1'b1;
      out_sof <= 1'b1;
      out_eof <= (BYTES == 1);
    end else if (xfer) begin
      if (idx == IW'(BYTES - 1)) begin
        state   <= IDLE;
        idx     <= '0;
        word_q  <= '0;
        out_wr  <= 1'b0;
        out_sof <= 1'b0;
        out_eof <= 1'b0;
      end else begin
        idx     <= idx + IW'(1);
        word_q  <= word_q << 8;
        out_sof <= 1'b0;
        out_eof <= (idx == IW'(BYTES - 2));
      end
    end
  end

endmodule

// File: tb/tb_wide_byte_sched.sv
// Scoreboard bench for wide_byte_sched: grant table, back-to-back, stall, reset and drop sequences.
module tb_wide_byte_sched;

  localparam int DW = 480;
  localparam int CW = 32;
  localparam int NQ = 8;
  localparam int BY = DW / 8;
  localparam int QW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NQ*DW-1:0]  in_data;
  logic [NQ*CW-1:0]  in_ctl;
  logic [NQ-1:0]     in_valid;
  logic [NQ-1:0]     in_rdy;
  logic [7:0]        out_data;
  logic              out_wr;
  logic              out_rdy;
  logic              out_sof;
  logic              out_eof;
  logic [QW-1:0]     out_qid;
  logic [CW-1:0]     out_ctl;

  typedef struct packed {
    logic [7:0]    data;
    logic          sof;
    logic          eof;
    logic [QW-1:0] qid;
    logic [CW-1:0] ctl;
  } exp_t;

  typedef struct {
    logic [7:0]    seed;
    logic [NQ-1:0] valid;
    logic [NQ-1:0] grant;
  } vec_t;

  exp_t       sb[$];
  int         glog[$];
  logic [7:0] seed[NQ];
  int         n_cmp = 0;
  int         n_err = 0;
  int         byte_count = 0;
  logic       stall = 1'b0;
  int         phase = 0;
  vec_t       tbl[7];

  always #5 clk = ~clk;

  wide_byte_sched #(
    .DATA_WIDTH(DW),
    .CTRL_WIDTH(CW),
    .NUM_QUEUES(NQ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_ctl  (in_ctl),
    .in_valid(in_valid),
    .in_rdy  (in_rdy),
    .out_data(out_data),
    .out_wr  (out_wr),
    .out_rdy (out_rdy),
    .out_sof (out_sof),
    .out_eof (out_eof),
    .out_qid (out_qid),
    .out_ctl (out_ctl)
  );

  // Queue q byte k = seed[q] + k, MSB byte first.
  always_comb begin
    in_data = '0;
    in_ctl  = '0;
    for (int q = 0; q < NQ; q++) begin
      for (int k = 0; k < BY; k++) in_data[q*DW + DW-1-8*k -: 8] = seed[q] + 8'(k);
      in_ctl[q*CW +: CW] = {8'hC0, seed[q], 8'h5A, 8'(q)};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (stall) begin
      out_rdy = (phase == 0) || (phase == 3);
      phase   = (phase + 1) % 4;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((out_wr || sb.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", 64'(n < budget), 64'd1);
  endtask

  // Output monitor: compares every shown byte to the scoreboard head, pops on transfer,
  // and loads the expected bytes of each newly granted word.
  always @(negedge clk) begin
    exp_t act;
    int   g;
    if (!rst) begin
      act = '{data: out_data, sof: out_sof, eof: out_eof, qid: out_qid, ctl: out_ctl};
      if (out_wr) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(act), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          chk("byte", 64'(act), 64'(sb[0]));
          if (out_rdy) begin
            void'(sb.pop_front());
            byte_count++;
          end
        end
      end else begin
        chk("idle_zero", {out_data, out_sof, out_eof}, 64'd0);
      end
      if (|in_rdy) begin
        g = 0;
        for (int i = 0; i < NQ; i++) if (in_rdy[i]) g = i;
        glog.push_back(g);
        for (int k = 0; k < BY; k++)
          sb.push_back('{data: seed[g] + 8'(k), sof: (k == 0), eof: (k == BY-1),
                         qid: QW'(g), ctl: {8'hC0, seed[g], 8'h5A, 8'(g)}});
      end
    end
  end

  initial begin
    int n;
    int bub;
    bit started;
    int exp_order[6];

    tbl[0] = '{seed: 8'h89, valid: 8'h08, grant: 8'h08};
    tbl[1] = '{seed: 8'h10, valid: 8'h40, grant: 8'h40};
    tbl[2] = '{seed: 8'h22, valid: 8'h81, grant: 8'h80};
    tbl[3] = '{seed: 8'h37, valid: 8'h81, grant: 8'h01};
    tbl[4] = '{seed: 8'h4C, valid: 8'hFF, grant: 8'h02};
    tbl[5] = '{seed: 8'h91, valid: 8'h03, grant: 8'h01};
    tbl[6] = '{seed: 8'hA5, valid: 8'h00, grant: 8'h00};
    exp_order = '{0, 2, 7, 0, 2, 7};

    rst = 1'b1;
    in_valid = '0;
    out_rdy = 1'b1;
    for (int q = 0; q < NQ; q++) seed[q] = 8'(q);
    repeat (2) cycle();
    in_valid = '1;
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 64'd0);
    chk("rst_outputs", {out_data, out_wr, out_sof, out_eof, out_qid, out_ctl}, 64'd0);
    cycle();
    in_valid = '0;
    rst = 1'b0;

    // Grant table from IDLE; vector 0 is queue 3 with bytes 0x01..0x3C.
    for (int i = 0; i < 7; i++) begin
      for (int q = 0; q < NQ; q++) seed[q] = tbl[i].seed + 8'(q*40);
      cycle();
      in_valid = tbl[i].valid;
      @(negedge clk);
      chk("grant", in_rdy, tbl[i].grant);
      cycle();
      in_valid = '0;
      if (tbl[i].grant != '0) begin
        @(negedge clk);
        chk("latency_sof", {out_wr, out_sof}, 64'd3);
      end
      wait_idle(400);
    end

    // Reset at byte index 30.
    for (int q = 0; q < NQ; q++) seed[q] = 8'(q*17 + 3);
    byte_count = 0;
    cycle();
    in_valid = 8'h08;
    cycle();
    in_valid = '0;
    n = 0;
    while (byte_count < 30 && n < 200) begin
      cycle();
      n++;
    end
    chk("reach_idx30", byte_count, 64'd30);
    rst = 1'b1;
    sb.delete();
    cycle();
    @(negedge clk);
    chk("midword_rst_outputs", {out_data, out_wr, out_sof, out_eof, out_qid, out_ctl}, 64'd0);
    chk("midword_rst_in_rdy", in_rdy, 64'd0);
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_idle", out_wr, 64'd0);
    end

    // Queues 0, 2, 7 continuously valid: round-robin with no bubbles.
    for (int q = 0; q < NQ; q++) seed[q] = 8'(q*29 + 7);
    glog.delete();
    cycle();
    in_valid = 8'h85;
    n = 0;
    bub = 0;
    started = 0;
    while (glog.size() < 6 && n < 1000) begin
      cycle();
      n++;
      if (out_wr) started = 1;
      else if (started) bub++;
    end
    in_valid = '0;
    chk("rr_grant_count", glog.size(), 64'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], exp_order[i]);
    chk("rr_bubbles", bub, 64'd0);
    wait_idle(400);

    // out_rdy pattern 1,0,0,1 on a single word from queue 1.
    for (int q = 0; q < NQ; q++) seed[q] = 8'(q*5 + 100);
    byte_count = 0;
    phase = 0;
    stall = 1'b1;
    cycle();
    in_valid = 8'h02;
    cycle();
    in_valid = '0;
    wait_idle(600);
    stall = 1'b0;
    out_rdy = 1'b1;
    chk("stall_byte_total", byte_count, BY);

    // Active queue drops in_valid after 10 bytes.
    for (int q = 0; q < NQ; q++) seed[q] = 8'(q*3 + 200);
    byte_count = 0;
    cycle();
    in_valid = 8'h20;
    n = 0;
    while (byte_count < 10 && n < 200) begin
      cycle();
      n++;
    end
    in_valid = '0;
    wait_idle(400);
    chk("drop_byte_total", byte_count, BY);
    chk("sb_drained", sb.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
